nibble_stack_writer: RTL and testbench

Write-side counterpart to the stack calculator's 16-way nibble read selector. It holds sixteen 4-bit entries and exposes them in parallel so a 16:1 read mux can pick any one of them. It updates the entries by push, pop, or indexed write, one operation per clock. It tracks stack depth and reports full, empty, overflow and underflow to the calculator control logic.

---
 rtl/nibble_stack_writer.sv | 122 ++++++++++++
 tb/tb_nibble_stack_writer.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/nibble_stack_writer.sv
// nibble_stack_writer: sixteen 4-bit entries, managed as a push-down stack.
// Entry 0 is the top of stack. All entries are presented in parallel on q
// so an external 16:1 read selector can address any of them in the same
// cycle. One operation is accepted per clock (push, pop or indexed write).
// The block reports depth, full, empty and one-cycle overflow/underflow pulses.
module nibble_stack_writer (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  op,
  input  logic [3:0]  d,
  input  logic [3:0]  s,
  output logic [63:0] q,
  output logic [4:0]  depth,
  output logic        empty,
  output logic        full,
  output logic        ovf,
  output logic        unf
);

  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_PUSH  = 2'b01;
  localparam logic [1:0] OP_POP   = 2'b10;
  localparam logic [1:0] OP_WRITE = 2'b11;

  localparam logic [4:0] DEPTH_MAX = 5'd16;

  logic [3:0] r_entry [16];
  logic [4:0] r_depth;
  logic       r_empty;
  logic       r_full;
  logic       r_ovf;
  logic       r_unf;

  logic       w_push_ok;
  logic       w_pop_ok;
  logic       w_push_rej;
  logic       w_pop_rej;
  logic [4:0] w_depth_nxt;

  // Classify the requested operation against the current depth and form the next depth.
  always_comb begin
    w_push_ok   = 1'b0;
    w_pop_ok    = 1'b0;
    w_push_rej  = 1'b0;
    w_pop_rej   = 1'b0;
    w_depth_nxt = r_depth;
    case (op)
      OP_PUSH: begin
        if (r_depth == DEPTH_MAX) begin
          w_push_rej = 1'b1;
        end else begin
          w_push_ok   = 1'b1;
          w_depth_nxt = r_depth + 5'd1;
        end
      end
      OP_POP: begin
        if (r_depth == 5'd0) begin
          w_pop_rej = 1'b1;
        end else begin
          w_pop_ok    = 1'b1;
          w_depth_nxt = r_depth - 5'd1;
        end
      end
      OP_NOP, OP_WRITE: begin
        w_depth_nxt = r_depth;
      end
      default: begin
        w_depth_nxt = r_depth;
      end
    endcase
  end

  // Entry storage: shift down on push, shift up with zero fill on pop, or write one entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 16; k++) begin
        r_entry[k] <= 4'h0;
      end
    end else if (w_push_ok) begin
      for (int k = 15; k > 0; k--) begin
        r_entry[k] <= r_entry[k-1];
      end
      r_entry[0] <= d;
    end else if (w_pop_ok) begin
      for (int k = 0; k < 15; k++) begin
        r_entry[k] <= r_entry[k+1];
      end
      r_entry[15] <= 4'h0;
    end else if (op == OP_WRITE) begin
      r_entry[s] <= d;
    end
  end

  // Depth and status flags; empty/full come from the next depth so they track the depth output.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_depth <= 5'd0;
      r_empty <= 1'b1;
      r_full  <= 1'b0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else begin
      r_depth <= w_depth_nxt;
      r_empty <= (w_depth_nxt == 5'd0);
      r_full  <= (w_depth_nxt == DEPTH_MAX);
      r_ovf   <= w_push_rej;
      r_unf   <= w_pop_rej;
    end
  end

  // Flatten the entries onto q, entry k in nibble k.
  for (genvar g = 0; g < 16; g++) begin : g_q
    assign q[4*g +: 4] = r_entry[g];
  end

  assign depth = r_depth;
  assign empty = r_empty;
  assign full  = r_full;
  assign ovf   = r_ovf;
  assign unf   = r_unf;

endmodule

// File: tb/tb_nibble_stack_writer.sv
// Testbench for nibble_stack_writer: directed scenarios plus a randomized run,
// all compared against a queue-based stack model.
module tb_nibble_stack_writer;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  op;
  logic [3:0]  d;
  logic [3:0]  s;
  logic [63:0] q;
  logic [4:0]  depth;
  logic        empty;
  logic        full;
  logic        ovf;
  logic        unf;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: mq holds all 16 entries, index 0 = top of stack.
  logic [3:0] mq[$];
  int         m_depth;
  logic       m_ovf;
  logic       m_unf;

  nibble_stack_writer dut (
    .clk   (clk),
    .rst   (rst),
    .op    (op),
    .d     (d),
    .s     (s),
    .q     (q),
    .depth (depth),
    .empty (empty),
    .full  (full),
    .ovf   (ovf),
    .unf   (unf)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] exp_q();
    logic [63:0] v;
    v = '0;
    for (int k = 0; k < 16; k++) v[4*k +: 4] = mq[k];
    return v;
  endfunction

  // {depth, empty, full, ovf, unf}
  function automatic logic [8:0] exp_st();
    logic [4:0] dp;
    dp = m_depth[4:0];
    return {dp, (m_depth == 0), (m_depth == 16), m_ovf, m_unf};
  endfunction

  function automatic logic [8:0] act_st();
    return {depth, empty, full, ovf, unf};
  endfunction

  // Drive one operation, wait for the edge, then advance the model.
  task automatic step(input logic r, input logic [1:0] o, input logic [3:0] dd, input logic [3:0] ss);
    @(negedge clk);
    rst = r; op = o; d = dd; s = ss;
    @(posedge clk);
    #1;
    m_ovf = 1'b0;
    m_unf = 1'b0;
    if (r) begin
      mq = {};
      repeat (16) mq.push_back(4'h0);
      m_depth = 0;
    end else begin
      case (o)
        2'b01: if (m_depth == 16) m_ovf = 1'b1;
               else begin mq.push_front(dd); void'(mq.pop_back()); m_depth++; end
        2'b10: if (m_depth == 0) m_unf = 1'b1;
               else begin void'(mq.pop_front()); mq.push_back(4'h0); m_depth--; end
        2'b11: mq[ss] = dd;
        default: ;
      endcase
    end
    rst = 1'b0; op = 2'b00;
  endtask

  task automatic test_reset();
    step(1'b1, 2'b00, 4'h0, 4'h0);
    n_cmp++;
    if (q !== 64'h0) begin n_err++; $display("FAIL reset_q: got %h want %h", q, 64'h0); end
    n_cmp++;
    if (act_st() !== 9'b00000_1_0_0_0) begin
      n_err++; $display("FAIL reset_status: got %b want %b", act_st(), 9'b00000_1_0_0_0);
    end
  endtask

  task automatic test_push_basic();
    step(1'b1, 2'b00, 4'h0, 4'h0);
    step(1'b0, 2'b01, 4'h3, 4'h0);
    step(1'b0, 2'b01, 4'hA, 4'h0);
    step(1'b0, 2'b01, 4'h7, 4'h0);
    n_cmp++;
    if (q[11:0] !== 12'hA7 + 12'h300) begin n_err++; $display("FAIL push3_q: got %h want %h", q[11:0], 12'h3A7); end
    n_cmp++;
    if (act_st() !== 9'b00011_0_0_0_0) begin
      n_err++; $display("FAIL push3_status: got %b want %b", act_st(), 9'b00011_0_0_0_0);
    end
    n_cmp++;
    if (q !== exp_q()) begin n_err++; $display("FAIL push3_model_q: got %h want %h", q, exp_q()); end
  endtask

  task automatic test_fill_overflow();
    logic [63:0] q_full;
    step(1'b1, 2'b00, 4'h0, 4'h0);
    for (int i = 1; i <= 16; i++) begin
      logic [4:0] iv;
      iv = 5'(i);
      step(1'b0, 2'b01, iv[3:0], 4'h0);
    end
    n_cmp++;
    if (act_st() !== 9'b10000_0_1_0_0) begin
      n_err++; $display("FAIL fill_status: got %b want %b", act_st(), 9'b10000_0_1_0_0);
    end
    n_cmp++;
    if (q[3:0] !== 4'h0 || q[63:60] !== 4'h1) begin
      n_err++; $display("FAIL fill_ends: got top %h bottom %h want 0 1", q[3:0], q[63:60]);
    end
    n_cmp++;
    if (q !== exp_q()) begin n_err++; $display("FAIL fill_model_q: got %h want %h", q, exp_q()); end
    q_full = q;
    step(1'b0, 2'b01, 4'h5, 4'h0);
    n_cmp++;
    if (act_st() !== 9'b10000_0_1_1_0) begin
      n_err++; $display("FAIL ovf_status: got %b want %b", act_st(), 9'b10000_0_1_1_0);
    end
    n_cmp++;
    if (q !== q_full) begin n_err++; $display("FAIL ovf_q_kept: got %h want %h", q, q_full); end
    step(1'b0, 2'b00, 4'h0, 4'h0);
    n_cmp++;
    if (ovf !== 1'b0 || depth !== 5'd16) begin
      n_err++; $display("FAIL ovf_pulse_end: got ovf %b depth %0d want 0 16", ovf, depth);
    end
  endtask

  task automatic test_pop_underflow();
    step(1'b1, 2'b00, 4'h0, 4'h0);
    step(1'b0, 2'b01, 4'h4, 4'h0);
    step(1'b0, 2'b01, 4'h9, 4'h0);
    step(1'b0, 2'b10, 4'h0, 4'h0);
    n_cmp++;
    if (q[3:0] !== 4'h4 || depth !== 5'd1) begin
      n_err++; $display("FAIL pop1: got top %h depth %0d want 4 1", q[3:0], depth);
    end
    step(1'b0, 2'b10, 4'h0, 4'h0);
    n_cmp++;
    if (q !== 64'h0 || act_st() !== 9'b00000_1_0_0_0) begin
      n_err++; $display("FAIL pop2: got q %h st %b want 0 %b", q, act_st(), 9'b00000_1_0_0_0);
    end
    step(1'b0, 2'b10, 4'h0, 4'h0);
    n_cmp++;
    if (q !== 64'h0 || act_st() !== 9'b00000_1_0_0_1) begin
      n_err++; $display("FAIL unf: got q %h st %b want 0 %b", q, act_st(), 9'b00000_1_0_0_1);
    end
    step(1'b0, 2'b00, 4'h0, 4'h0);
    n_cmp++;
    if (unf !== 1'b0) begin n_err++; $display("FAIL unf_pulse_end: got %b want 0", unf); end
  endtask

  task automatic test_indexed_write();
    logic [63:0] q0;
    step(1'b1, 2'b00, 4'h0, 4'h0);
    for (int i = 0; i < 3; i++) step(1'b0, 2'b01, 4'($urandom_range(0, 15)), 4'h0);
    q0 = q;
    step(1'b0, 2'b11, 4'hC, 4'h1);
    n_cmp++;
    if (q[7:4] !== 4'hC || q[3:0] !== q0[3:0] || q[11:8] !== q0[11:8] || depth !== 5'd3) begin
      n_err++; $display("FAIL wr_s1: got q %h depth %0d want e1=C e0=%h e2=%h depth 3", q, depth, q0[3:0], q0[11:8]);
    end
    step(1'b0, 2'b11, 4'h6, 4'hF);
    n_cmp++;
    if (q[63:60] !== 4'h6 || act_st() !== 9'b00011_0_0_0_0) begin
      n_err++; $display("FAIL wr_s15: got e15 %h st %b want 6 %b", q[63:60], act_st(), 9'b00011_0_0_0_0);
    end
    n_cmp++;
    if (q !== exp_q()) begin n_err++; $display("FAIL wr_model_q: got %h want %h", q, exp_q()); end
  endtask

  task automatic test_reset_mid();
    step(1'b1, 2'b00, 4'h0, 4'h0);
    for (int i = 0; i < 5; i++) step(1'b0, 2'b01, 4'h1 + 4'(i), 4'h0);
    step(1'b1, 2'b01, 4'hE, 4'h0);
    n_cmp++;
    if (q !== 64'h0 || act_st() !== 9'b00000_1_0_0_0) begin
      n_err++; $display("FAIL reset_mid: got q %h st %b want 0 %b", q, act_st(), 9'b00000_1_0_0_0);
    end
  endtask

  task automatic test_back_to_back();
    step(1'b1, 2'b00, 4'h0, 4'h0);
    for (int i = 0; i < 8; i++) begin
      logic [4:0] ed;
      logic [3:0] et;
      ed = (i % 2 == 0) ? 5'd1 : 5'd0;
      et = (i % 2 == 0) ? 4'h2 : 4'h0;
      step(1'b0, (i % 2 == 0) ? 2'b01 : 2'b10, 4'h2, 4'h0);
      n_cmp++;
      if (depth !== ed || q[3:0] !== et || ovf !== 1'b0 || unf !== 1'b0) begin
        n_err++;
        $display("FAIL alt_%0d: got depth %0d top %h ovf %b unf %b want %0d %h 0 0", i, depth, q[3:0], ovf, unf, ed, et);
      end
    end
  endtask

  task automatic test_random();
    step(1'b1, 2'b00, 4'h0, 4'h0);
    for (int i = 0; i < 600; i++) begin
      int r;
      logic [1:0] o;
      r = $urandom_range(0, 9);
      if ((i / 100) % 2 == 0) o = (r < 6) ? 2'b01 : (r < 8) ? 2'b10 : (r == 8) ? 2'b11 : 2'b00;
      else                    o = (r < 6) ? 2'b10 : (r < 8) ? 2'b01 : (r == 8) ? 2'b11 : 2'b00;
      step(($urandom_range(0, 99) == 0), o, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      n_cmp++;
      if (q !== exp_q()) begin n_err++; $display("FAIL rnd_q_%0d: got %h want %h", i, q, exp_q()); end
      n_cmp++;
      if (act_st() !== exp_st()) begin n_err++; $display("FAIL rnd_st_%0d: got %b want %b", i, act_st(), exp_st()); end
    end
  endtask

  initial begin
    rst = 1'b1; op = 2'b00; d = 4'h0; s = 4'h0;
    test_reset();
    test_push_basic();
    test_fill_overflow();
    test_pop_underflow();
    test_indexed_write();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
